// File: rtl/ifu_mem_arb_if.sv
// Bundle of the cache-miss, prefetch, memory and status signals around the IFU memory arbiter.
// slave is the arbiter's view; master is the surrounding environment's view.
interface ifu_mem_arb_if #(
    parameter int unsigned TAG_WIDTH  = 28,
    parameter int unsigned LINE_WIDTH = 128
);
    logic [TAG_WIDTH-1:0]  cache_reqTagIn;
    logic                  cache_reqValidIn;
    logic                  cache_reqReadyOut;
    logic [TAG_WIDTH-1:0]  pf_reqTagIn;
    logic                  pf_reqValidIn;
    logic                  pf_reqReadyOut;
    logic [TAG_WIDTH-1:0]  mem_reqTagOut;
    logic                  mem_reqValidOut;
    logic                  mem_reqReadyIn;
    logic [TAG_WIDTH-1:0]  mem_rspTagIn;
    logic [LINE_WIDTH-1:0] mem_rspInsLineIn;
    logic                  mem_rspInsLineValidIn;
    logic [TAG_WIDTH-1:0]  cache_rspTagOut;
    logic [LINE_WIDTH-1:0] cache_rspInsLineOut;
    logic                  cache_rspInsLineValidOut;
    logic                  cache_rspIsPrefetchOut;
    logic                  busyOut;
    logic                  timeoutErrOut;

    modport slave (
        input  cache_reqTagIn, cache_reqValidIn, pf_reqTagIn, pf_reqValidIn,
               mem_reqReadyIn, mem_rspTagIn, mem_rspInsLineIn, mem_rspInsLineValidIn,
        output cache_reqReadyOut, pf_reqReadyOut, mem_reqTagOut, mem_reqValidOut,
               cache_rspTagOut, cache_rspInsLineOut, cache_rspInsLineValidOut,
               cache_rspIsPrefetchOut, busyOut, timeoutErrOut
    );

    modport master (
        output cache_reqTagIn, cache_reqValidIn, pf_reqTagIn, pf_reqValidIn,
               mem_reqReadyIn, mem_rspTagIn, mem_rspInsLineIn, mem_rspInsLineValidIn,
        input  cache_reqReadyOut, pf_reqReadyOut, mem_reqTagOut, mem_reqValidOut,
               cache_rspTagOut, cache_rspInsLineOut, cache_rspInsLineValidOut,
               cache_rspIsPrefetchOut, busyOut, timeoutErrOut
    );
endinterface

// File: rtl/ifu_mem_arb.sv
// Single-outstanding arbiter for the IFU memory port: demand misses beat prefetches,
// one request in flight, matching line forwarded to the cache, re-issue on response timeout.
module ifu_mem_arb #(
    parameter int unsigned TAG_WIDTH      = 28,
    parameter int unsigned LINE_WIDTH     = 128,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic          Clock,
    input logic          Rst,
    ifu_mem_arb_if.slave bus
);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

    state_e                state_q, state_d;
    logic [TAG_WIDTH-1:0]  cur_tag_q, cur_tag_d;
    logic                  is_pf_q, is_pf_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_pf_q, rsp_pf_d;
    logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;
    logic [LINE_WIDTH-1:0] rsp_line_q, rsp_line_d;

    logic cache_ready_c;
    logic pf_ready_c;
    logic mem_valid_c;
    logic promo_hit_c;
    logic rsp_hit_c;

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            state_q       <= S_IDLE;
            cur_tag_q     <= '0;
            is_pf_q       <= 1'b0;
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_pf_q      <= 1'b0;
            rsp_tag_q     <= '0;
            rsp_line_q    <= '0;
        end else begin
            state_q       <= state_d;
            cur_tag_q     <= cur_tag_d;
            is_pf_q       <= is_pf_d;
            timer_q       <= timer_d;
            timeout_err_q <= timeout_err_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_pf_q      <= rsp_pf_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_line_q    <= rsp_line_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cur_tag_d     = cur_tag_q;
        is_pf_d       = is_pf_q;
        timer_d       = timer_q;
        timeout_err_d = timeout_err_q;
        rsp_valid_d   = 1'b0;
        rsp_pf_d      = rsp_pf_q;
        rsp_tag_d     = rsp_tag_q;
        rsp_line_d    = rsp_line_q;
        cache_ready_c = 1'b0;
        pf_ready_c    = 1'b0;
        mem_valid_c   = 1'b0;

        // A demand miss for the in-flight prefetch tag upgrades it instead of queuing
        promo_hit_c = is_pf_q && (bus.cache_reqTagIn == cur_tag_q);
        rsp_hit_c   = bus.mem_rspInsLineValidIn && (bus.mem_rspTagIn == cur_tag_q);

        unique case (state_q)
            S_IDLE: begin
                cache_ready_c = 1'b1;
                pf_ready_c    = !bus.cache_reqValidIn ||
                                (bus.pf_reqValidIn && (bus.pf_reqTagIn == bus.cache_reqTagIn));
                if (bus.cache_reqValidIn) begin
                    cur_tag_d = bus.cache_reqTagIn;
                    is_pf_d   = 1'b0;
                    state_d   = S_ISSUE;
                end else if (bus.pf_reqValidIn) begin
                    cur_tag_d = bus.pf_reqTagIn;
                    is_pf_d   = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_valid_c   = 1'b1;
                cache_ready_c = promo_hit_c;
                if (bus.cache_reqValidIn && promo_hit_c) is_pf_d = 1'b0;
                if (bus.mem_reqReadyIn) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cache_ready_c = promo_hit_c;
                if (bus.cache_reqValidIn && promo_hit_c) is_pf_d = 1'b0;
                timer_d = timer_q + TMR_W'(1);
                // A match on the last timer cycle still wins over the re-issue
                if (rsp_hit_c) begin
                    rsp_valid_d = 1'b1;
                    rsp_pf_d    = is_pf_d;
                    rsp_tag_d   = bus.mem_rspTagIn;
                    rsp_line_d  = bus.mem_rspInsLineIn;
                    state_d     = S_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Readies are held low while reset is asserted so every output reads 0 in reset
    assign bus.cache_reqReadyOut        = cache_ready_c & ~Rst;
    assign bus.pf_reqReadyOut           = pf_ready_c & ~Rst;
    assign bus.mem_reqValidOut          = mem_valid_c;
    assign bus.mem_reqTagOut            = cur_tag_q;
    assign bus.cache_rspTagOut          = rsp_tag_q;
    assign bus.cache_rspInsLineOut      = rsp_line_q;
    assign bus.cache_rspInsLineValidOut = rsp_valid_q;
    assign bus.cache_rspIsPrefetchOut   = rsp_pf_q;
    assign bus.busyOut                  = (state_q != S_IDLE);
    assign bus.timeoutErrOut            = timeout_err_q;
endmodule

// File: tb/tb_ifu_mem_arb.sv
// Directed and randomized bench for ifu_mem_arb; expectations come from transaction-level
// rules (who wins, which tag, prefetch flag, latency) tracked in the bench.
module tb_ifu_mem_arb;
    localparam int unsigned TW = 28;
    localparam int unsigned LW = 128;
    localparam int unsigned TO = 64;

    logic Clock = 1'b0;
    logic Rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 Clock = ~Clock;

    ifu_mem_arb_if #(.TAG_WIDTH(TW), .LINE_WIDTH(LW)) bus ();

    ifu_mem_arb #(.TAG_WIDTH(TW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
        .Clock (Clock),
        .Rst   (Rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_in();
        bus.cache_reqTagIn        = '0;
        bus.cache_reqValidIn      = 1'b0;
        bus.pf_reqTagIn           = '0;
        bus.pf_reqValidIn         = 1'b0;
        bus.mem_reqReadyIn        = 1'b0;
        bus.mem_rspTagIn          = '0;
        bus.mem_rspInsLineIn      = '0;
        bus.mem_rspInsLineValidIn = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cready"}, bus.cache_reqReadyOut, 0);
        chk({tag, "_pready"}, bus.pf_reqReadyOut, 0);
        chk({tag, "_mvalid"}, bus.mem_reqValidOut, 0);
        chk({tag, "_mtag"}, bus.mem_reqTagOut, 0);
        chk({tag, "_rvalid"}, bus.cache_rspInsLineValidOut, 0);
        chk({tag, "_rtag"}, bus.cache_rspTagOut, 0);
        chk({tag, "_rline"}, bus.cache_rspInsLineOut, 0);
        chk({tag, "_rpf"}, bus.cache_rspIsPrefetchOut, 0);
        chk({tag, "_busy"}, bus.busyOut, 0);
        chk({tag, "_err"}, bus.timeoutErrOut, 0);
    endtask

    // Present requests in an IDLE cycle, check readies, let the edge accept them
    task automatic accept(input logic cv, input logic [TW-1:0] ct, input logic pv,
                          input logic [TW-1:0] pt, input logic exp_cr, input logic exp_pr);
        bus.cache_reqValidIn = cv;
        bus.cache_reqTagIn   = ct;
        bus.pf_reqValidIn    = pv;
        bus.pf_reqTagIn      = pt;
        settle();
        chk("accept_cready", bus.cache_reqReadyOut, exp_cr);
        chk("accept_pready", bus.pf_reqReadyOut, exp_pr);
        chk("accept_busy", bus.busyOut, 0);
        tick();
        idle_in();
    endtask

    // From the ISSUE cycle: memory handshake, wait, optional promotion, matching response.
    // mode: 0 none, 1 matching demand early in WAIT, 2 other-tag demand in WAIT,
    // 3 matching demand in the response cycle.
    task automatic serve(input logic [TW-1:0] tag, input logic exp_pf_in, input int rdy_dly,
                         input int rsp_dly, input int mode, input logic [LW-1:0] line);
        logic exp_pf;
        int   d;
        exp_pf = exp_pf_in;
        d      = rsp_dly;
        if ((mode == 1 || mode == 2) && d == 0) d = 1;
        for (int i = 0; i <= rdy_dly; i++) begin
            bus.mem_reqReadyIn = (i == rdy_dly);
            settle();
            chk("issue_valid", bus.mem_reqValidOut, 1);
            chk("issue_tag", bus.mem_reqTagOut, tag);
            chk("issue_busy", bus.busyOut, 1);
            chk("issue_pready", bus.pf_reqReadyOut, 0);
            if (i == 0) chk("rsp_pulse_end", bus.cache_rspInsLineValidOut, 0);
            tick();
        end
        bus.mem_reqReadyIn = 1'b0;
        for (int k = 0; k < d; k++) begin
            bus.mem_rspInsLineValidIn = (k % 3 == 1);
            bus.mem_rspTagIn          = tag ^ TW'(k + 1);
            bus.mem_rspInsLineIn      = {4{$urandom}};
            if (k == 0 && mode == 1) begin
                bus.cache_reqValidIn = 1'b1;
                bus.cache_reqTagIn   = tag;
                settle();
                chk("promo_ready", bus.cache_reqReadyOut, 1);
                exp_pf = 1'b0;
            end else if (k == 0 && mode == 2) begin
                bus.cache_reqValidIn = 1'b1;
                bus.cache_reqTagIn   = tag ^ TW'(1);
                settle();
                chk("promo_other_ready", bus.cache_reqReadyOut, 0);
            end else begin
                settle();
            end
            chk("wait_mvalid", bus.mem_reqValidOut, 0);
            tick();
            idle_in();
        end
        bus.mem_rspInsLineValidIn = 1'b1;
        bus.mem_rspTagIn          = tag;
        bus.mem_rspInsLineIn      = line;
        if (mode == 3) begin
            bus.cache_reqValidIn = 1'b1;
            bus.cache_reqTagIn   = tag;
            settle();
            chk("promo_rsp_ready", bus.cache_reqReadyOut, exp_pf);
            exp_pf = 1'b0;
        end
        tick();
        idle_in();
        settle();
        chk("rsp_valid", bus.cache_rspInsLineValidOut, 1);
        chk("rsp_tag", bus.cache_rspTagOut, tag);
        chk("rsp_line", bus.cache_rspInsLineOut, line);
        chk("rsp_is_pf", bus.cache_rspIsPrefetchOut, exp_pf);
        chk("rsp_busy", bus.busyOut, 0);
        chk("rsp_mvalid", bus.mem_reqValidOut, 0);
    endtask

    initial begin
        logic          cv, pv, exp_pf;
        logic [TW-1:0] ct, pt, exp_tag;
        int            mode;

        Rst = 1'b1;
        idle_in();
        #2;
        chk_all_zero("reset");
        tick();
        tick();
        Rst = 1'b0;
        settle();
        chk("post_reset_cready", bus.cache_reqReadyOut, 1);
        chk("post_reset_busy", bus.busyOut, 0);

        // Demand only, minimum latency
        accept(1'b1, TW'('h0000123), 1'b0, '0, 1'b1, 1'b0);
        serve(TW'('h0000123), 1'b0, 0, 0, 0, {16{8'hA5}});

        // Demand beats a different-tag prefetch; prefetch served afterwards
        accept(1'b1, TW'('h10), 1'b1, TW'('h20), 1'b1, 1'b0);
        serve(TW'('h10), 1'b0, 1, 2, 0, {4{$urandom}});
        accept(1'b0, '0, 1'b1, TW'('h20), 1'b1, 1'b1);
        serve(TW'('h20), 1'b1, 0, 1, 0, {4{$urandom}});

        // Equal tags merge into one demand request
        accept(1'b1, TW'('h30), 1'b1, TW'('h30), 1'b1, 1'b1);
        serve(TW'('h30), 1'b0, 0, 3, 0, {4{$urandom}});

        // Promotion: other tag refused, matching tag upgrades the prefetch
        accept(1'b0, '0, 1'b1, TW'('h40), 1'b1, 1'b1);
        serve(TW'('h40), 1'b1, 0, 2, 2, {4{$urandom}});
        accept(1'b0, '0, 1'b1, TW'('h40), 1'b1, 1'b1);
        serve(TW'('h40), 1'b1, 2, 3, 1, {4{$urandom}});
        accept(1'b0, '0, 1'b1, TW'('h42), 1'b1, 1'b1);
        serve(TW'('h42), 1'b1, 0, 2, 3, {4{$urandom}});

        // Match on the last allowed WAIT cycle beats the timeout
        accept(1'b1, TW'('h66), 1'b0, '0, 1'b1, 1'b0);
        serve(TW'('h66), 1'b0, 0, TO - 1, 0, {4{$urandom}});
        chk("boundary_no_err", bus.timeoutErrOut, 0);

        // Full timeout: wrong-tag response ignored, then re-issue with the same tag
        accept(1'b1, TW'('h55), 1'b0, '0, 1'b1, 1'b0);
        bus.mem_reqReadyIn = 1'b1;
        settle();
        chk("to_issue_valid", bus.mem_reqValidOut, 1);
        tick();
        idle_in();
        for (int k = 0; k < int'(TO); k++) begin
            bus.mem_rspInsLineValidIn = (k == 10);
            bus.mem_rspTagIn          = TW'('h56);
            settle();
            if (k == int'(TO) - 1) begin
                chk("to_last_wait_mvalid", bus.mem_reqValidOut, 0);
                chk("to_last_wait_err", bus.timeoutErrOut, 0);
            end
            tick();
            idle_in();
        end
        settle();
        chk("to_reissue_valid", bus.mem_reqValidOut, 1);
        chk("to_reissue_tag", bus.mem_reqTagOut, TW'('h55));
        chk("to_err", bus.timeoutErrOut, 1);
        chk("to_no_rsp", bus.cache_rspInsLineValidOut, 0);
        serve(TW'('h55), 1'b0, 0, 2, 0, {4{$urandom}});
        chk("to_err_sticky", bus.timeoutErrOut, 1);

        // Randomized transactions against arbitration rules
        for (int n = 0; n < 40; n++) begin
            cv = 1'($urandom_range(0, 1));
            pv = 1'($urandom_range(0, 1));
            if (!cv && !pv) pv = 1'b1;
            ct = TW'($urandom);
            pt = ($urandom_range(0, 2) == 0) ? ct : TW'($urandom);
            exp_tag = cv ? ct : pt;
            exp_pf  = !cv;
            mode    = exp_pf ? int'($urandom_range(0, 3)) : 0;
            accept(cv, ct, pv, pt, 1'b1, !cv || (pv && (ct == pt)));
            serve(exp_tag, exp_pf, int'($urandom_range(0, 3)), int'($urandom_range(0, 8)),
                  mode, {4{$urandom}});
        end

        // Reset in WAIT abandons the request; late response is dropped
        accept(1'b1, TW'('h77), 1'b0, '0, 1'b1, 1'b0);
        bus.mem_reqReadyIn = 1'b1;
        settle();
        chk("rst_issue_valid", bus.mem_reqValidOut, 1);
        tick();
        idle_in();
        Rst = 1'b1;
        settle();
        chk_all_zero("rst_mid");
        tick();
        Rst = 1'b0;
        bus.mem_rspInsLineValidIn = 1'b1;
        bus.mem_rspTagIn          = TW'('h77);
        bus.mem_rspInsLineIn      = {4{$urandom}};
        settle();
        chk("rst_after_cready", bus.cache_reqReadyOut, 1);
        tick();
        idle_in();
        settle();
        chk("rst_late_rvalid", bus.cache_rspInsLineValidOut, 0);
        chk("rst_late_rtag", bus.cache_rspTagOut, 0);
        chk("rst_late_busy", bus.busyOut, 0);
        chk("rst_late_mvalid", bus.mem_reqValidOut, 0);
        chk("rst_late_err", bus.timeoutErrOut, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ifu_mem_arb.md
# ifu_mem_arb

Single-outstanding arbiter and sequencer for the IFU memory port. It sits between the instruction cache miss path, the instruction prefetcher and the memory. It arbitrates demand misses (always preferred) against prefetch requests and drives one request at a time to memory with a valid/ready handshake. It waits for the matching line, returns it to the cache with a demand/prefetch flag, and re-issues the request after a response timeout.

## Interface
Parameters:
- TAG_WIDTH, 28, line tag width (address minus line offset)
- LINE_WIDTH, 128, instruction line width in bits
- TIMEOUT_CYCLES, 64, cycles allowed in WAIT before re-issue; counter width is $clog2(TIMEOUT_CYCLES+1)

Ports:
- Clock  in  1  clock; all state updates on posedge
- Rst  in  1  asynchronous, active-high reset
- cache_reqTagIn  in  TAG_WIDTH  demand miss tag
- cache_reqValidIn  in  1  demand miss pending; held until accepted
- cache_reqReadyOut  out  1  demand request accepted when valid&ready
- pf_reqTagIn  in  TAG_WIDTH  prefetch tag
- pf_reqValidIn  in  1  prefetch request pending
- pf_reqReadyOut  out  1  prefetch accepted when valid&ready
- mem_reqTagOut  out  TAG_WIDTH  tag sent to memory
- mem_reqValidOut  out  1  request valid; held until mem_reqReadyIn
- mem_reqReadyIn  in  1  memory accepts request
- mem_rspTagIn  in  TAG_WIDTH  tag of returned line
- mem_rspInsLineIn  in  LINE_WIDTH  returned line
- mem_rspInsLineValidIn  in  1  response valid, single-cycle
- cache_rspTagOut  out  TAG_WIDTH  tag of line forwarded to cache
- cache_rspInsLineOut  out  LINE_WIDTH  forwarded line
- cache_rspInsLineValidOut  out  1  one-cycle pulse, line ready for insertion
- cache_rspIsPrefetchOut  out  1  forwarded line was prefetch-only
- busyOut  out  1  state != IDLE
- timeoutErrOut  out  1  sticky; set on first timeout, cleared only by Rst

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE
  - cache_reqReadyOut=1; pf_reqReadyOut=!cache_reqValidIn, or 1 when both valids are high and both tags are equal.
  - On accept, capture the tag in curTag and set isPf=0 for demand or isPf=1 for prefetch-only.
  - If both requests are accepted with equal tags, they merge into one request with isPf=0.
  - Then go to ISSUE.
- ISSUE
  - mem_reqValidOut=1, mem_reqTagOut=curTag.
  - On mem_reqReadyIn, clear the timer and go to WAIT.
- WAIT
  - The timer increments each cycle.
  - A response with mem_rspTagIn==curTag captures the line and tag into the output registers, pulses cache_rspInsLineValidOut next cycle with cache_rspIsPrefetchOut=isPf, and goes to IDLE.
  - Non-matching responses are ignored.
  - When the timer reaches TIMEOUT_CYCLES-1 without a match, set timeoutErrOut and go to ISSUE (re-issue the same tag, same isPf).
- Promotion
  - In ISSUE or WAIT with isPf=1, cache_reqReadyOut=1 iff cache_reqTagIn==curTag.
  - Accepting that request clears isPf.
  - Otherwise cache_reqReadyOut=0 and pf_reqReadyOut=0 outside IDLE.
- Responses arriving in IDLE or ISSUE are dropped.

## Timing
- Reset values: all outputs 0; state IDLE; curTag, isPf, timer, output line/tag registers 0; cache_reqReadyOut becomes 1 combinationally after reset deasserts (IDLE).
- Ready outputs and mem_req* are combinational from state/registers and inputs; cache_rsp* are registered.
- Accept at edge N → mem_reqValidOut high in cycle N+1.
- Memory ready in cycle M → WAIT from M+1; matching response in cycle R → cache_rspInsLineValidOut high exactly cycle R+1, state IDLE in R+1, new request acceptable in R+1.
- Minimum request-to-line: accept(0), issue/ready(1), response(2), line out(3).
- Promotion in the same cycle as the matching response: the forwarded line has cache_rspIsPrefetchOut=0.
- Timeout boundary: a matching response in the same cycle the timer hits the limit wins (no re-issue, no error).
- Rst asserted mid-transaction: immediate return to IDLE, in-flight request abandoned, a late memory response after reset is dropped.

## Test plan
- Demand only, tag 0x0000123, memory ready in issue cycle, response 1 cycle later with line 0xA5…A5 → cache_rspInsLineValidOut pulse at cycle 3, tag 0x0000123, isPrefetch=0.
- Demand 0x10 and prefetch 0x20 valid together → only demand accepted, pf_reqReadyOut=0; after completion prefetch 0x20 accepted and returned with isPrefetch=1.
- Both valid with tag 0x30 → both ready=1, one memory request, one response with isPrefetch=0.
- Prefetch 0x40 in WAIT, demand 0x40 arrives → cache_reqReadyOut=1, response isPrefetch=0; demand 0x41 at that time → ready=0.
- No response for TIMEOUT_CYCLES=64 → timeoutErrOut=1, mem_reqValidOut re-asserted with same tag. Response with a wrong tag in WAIT → ignored.
- Rst pulse in WAIT, then response for the old tag → no cache_rspInsLineValidOut, all outputs 0, busyOut=0.
